// File: rtl/tiny_yolo_pkg.sv
// Shared constants and the loader state type for the weight-loading path.
// Latency: none (declarations only).
// Backpressure: n/a.
package tiny_yolo_pkg;
  localparam int NUM_BANKS  = 8;
  localparam int KPOS       = 9;
  localparam int BYTE_W     = 8;
  localparam int BEAT_BYTES = 8;
  localparam int BUF_BYTES  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } ld_state_t;
endpackage

// File: rtl/byte_gearbox_64to72.sv
// 16-byte FIFO gearbox: accepts 8-byte beats, emits 9-byte kernel words in stream order.
// Latency: a word is presented combinationally once 9 bytes are held; the pop takes effect at the next edge.
// Backpressure: none needed; popping whenever 9+ bytes are held keeps room for a push every cycle.
module byte_gearbox_64to72
  import tiny_yolo_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [BEAT_BYTES*8-1:0]  push_dat,
  input  logic                     pop_en,
  output logic                     pop_vld,
  output logic [KPOS*BYTE_W-1:0]   pop_dat
);
  logic [BYTE_W-1:0] buf_q [BUF_BYTES];
  logic [BYTE_W-1:0] buf_d [BUF_BYTES];
  logic [4:0]        cnt_q;
  logic [4:0]        cnt_d;
  logic [4:0]        idx;

  assign pop_vld = pop_en && (cnt_q >= 5'(KPOS));

  // Oldest nine bytes form the outgoing word, byte 0 at the bottom.
  always_comb begin
    pop_dat = '0;
    for (int p = 0; p < KPOS; p++) pop_dat[8*p +: 8] = buf_q[p];
  end

  // Next buffer image: shift out nine on pop, then append the beat behind what remains.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    idx   = '0;
    if (pop_vld) begin
      for (int i = 0; i < BUF_BYTES - KPOS; i++) buf_d[i] = buf_q[i+KPOS];
      for (int i = BUF_BYTES - KPOS; i < BUF_BYTES; i++) buf_d[i] = '0;
      cnt_d = cnt_q - 5'(KPOS);
    end
    if (push) begin
      for (int k = 0; k < BEAT_BYTES; k++) begin
        idx = cnt_d + 5'(k);
        if (idx < 5'(BUF_BYTES)) buf_d[idx[3:0]] = push_dat[8*k +: 8];
      end
      cnt_d = cnt_d + 5'(BEAT_BYTES);
    end
  end

  // Buffer storage and fill level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_BYTES; i++) buf_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/weight_loader.sv
// Streams 64-bit weight beats into eight 72-bit kernel banks, bank 0..7 per address.
// Latency: a bank write appears the cycle after its 9th byte is buffered; done one cycle after the last write.
// Backpressure: s_tready high throughout a load until all beats are taken; never throttles mid-load.
module weight_loader
  import tiny_yolo_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [ADDR_WIDTH:0]     num_words,
  input  logic [63:0]             s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  output logic [NUM_BANKS-1:0]    wen,
  output logic [KPOS*BYTE_W-1:0]  wdata,
  output logic [ADDR_WIDTH-1:0]   waddr,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  localparam int BW     = ADDR_WIDTH + 5;  // holds 9*num_words
  localparam int WW     = ADDR_WIDTH + 4;  // holds 8*num_words
  localparam int BANK_W = $clog2(NUM_BANKS);

  ld_state_t               state;
  logic [BW-1:0]           beats_rem;
  logic [WW-1:0]           writes_rem;
  logic [BANK_W-1:0]       bank_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    beat_acc;
  logic                    pop_vld;
  logic [KPOS*BYTE_W-1:0]  pop_dat;

  assign s_tready = (state == ST_LOAD) && (beats_rem != '0);
  assign beat_acc = s_tvalid && s_tready;

  byte_gearbox_64to72 u_gearbox (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (beat_acc),
    .push_dat (s_tdata),
    .pop_en   (state == ST_LOAD),
    .pop_vld  (pop_vld),
    .pop_dat  (pop_dat)
  );

  // Load sequencing: beat/write counting, bank and address stepping, registered outputs.
  // A zero-length load still shows busy for its single DONE cycle so the request is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      beats_rem  <= '0;
      writes_rem <= '0;
      bank_q     <= '0;
      addr_q     <= '0;
      wen        <= '0;
      wdata      <= '0;
      waddr      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      wen  <= '0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            err        <= 1'b0;
            bank_q     <= '0;
            addr_q     <= base_addr;
            beats_rem  <= BW'({num_words, 3'b000}) + BW'(num_words);
            writes_rem <= WW'({num_words, 3'b000});
            busy       <= 1'b1;
            if (num_words == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (beat_acc) begin
            beats_rem <= beats_rem - BW'(1);
            if (s_tlast != (beats_rem == BW'(1))) err <= 1'b1;
          end
          if (pop_vld) begin
            wen        <= {{(NUM_BANKS-1){1'b0}}, 1'b1} << bank_q;
            wdata      <= pop_dat;
            waddr      <= addr_q;
            bank_q     <= bank_q + BANK_W'(1);
            writes_rem <= writes_rem - WW'(1);
            if (bank_q == BANK_W'(NUM_BANKS-1)) addr_q <= addr_q + ADDR_WIDTH'(1);
          end
          if (writes_rem == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
